// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC controller: cause codes,
// default vectors and the next-PC select encoding.
package pc_pkg;

  localparam logic [4:0] CAUSE_INT  = 5'd0;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_OV   = 5'd12;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_3600;

  typedef enum logic [2:0] {
    SEL_RST,
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD,
    SEL_JMP,
    SEL_BR,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority encoder. With PC_ALIGN_CHK_EN defined, a misaligned
// eret/jump/branch target is flagged so the top can raise AdEL instead.
module pc_next_sel
  import pc_pkg::*;
(
  input  logic       rst,
  input  logic       exc_req,
  input  logic       eret,
  input  logic       exl,
  input  logic       pc_we,
  input  logic       jmp_take,
  input  logic       br_take,
  input  logic [1:0] epc_lo,
  input  logic [1:0] jmp_lo,
  input  logic [1:0] br_lo,
  output pc_sel_e    sel,
  output logic       align_fault
);

`ifdef PC_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic [1:0] tgt_lo;
  logic       loads_tgt;

  always_comb begin
    sel       = SEL_SEQ;
    tgt_lo    = '0;
    loads_tgt = 1'b0;
    if (rst) begin
      sel = SEL_RST;
    end else if (exc_req) begin
      sel = SEL_EXC;
    end else if (eret && exl) begin
      sel       = SEL_ERET;
      tgt_lo    = epc_lo;
      loads_tgt = 1'b1;
    end else if (!pc_we) begin
      sel = SEL_HOLD;
    end else if (jmp_take) begin
      sel       = SEL_JMP;
      tgt_lo    = jmp_lo;
      loads_tgt = 1'b1;
    end else if (br_take) begin
      sel       = SEL_BR;
      tgt_lo    = br_lo;
      loads_tgt = 1'b1;
    end
  end

  assign align_fault = ALIGN_CHK && loads_tgt && (tgt_lo != 2'b00);

endmodule

// File: rtl/pc_ctrl.sv
// MIPS fetch PC controller with precise exception entry/return (EPC, EXL,
// cause). Optional target alignment check under macro PC_ALIGN_CHK_EN.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned       STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_we,
  input  logic             br_take,
  input  logic [WIDTH-1:0] br_tgt,
  input  logic             jmp_take,
  input  logic [WIDTH-1:0] jmp_tgt,
  input  logic             eret,
  input  logic             exc_req,
  input  logic [4:0]       exc_code,
  input  logic [WIDTH-1:0] exc_pc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             exl,
  output logic [4:0]       cause,
  output logic             flush
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             exl_q, exl_d;
  logic [4:0]       cause_q, cause_d;
  logic             flush_q, flush_d;

  pc_sel_e sel;
  logic    align_fault;

  pc_next_sel u_sel (
    .rst         (rst),
    .exc_req     (exc_req),
    .eret        (eret),
    .exl         (exl_q),
    .pc_we       (pc_we),
    .jmp_take    (jmp_take),
    .br_take     (br_take),
    .epc_lo      (epc_q[1:0]),
    .jmp_lo      (jmp_tgt[1:0]),
    .br_lo       (br_tgt[1:0]),
    .sel         (sel),
    .align_fault (align_fault)
  );

  assign pc_plus = pc_q + WIDTH'(STEP);

  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    exl_d   = exl_q;
    cause_d = cause_q;
    flush_d = 1'b0;
    // A misaligned target replaces the redirect with an AdEL exception
    // whose return address is the current fetch PC.
    if (align_fault) begin
      pc_d    = EXC_VEC;
      cause_d = CAUSE_ADEL;
      exl_d   = 1'b1;
      flush_d = 1'b1;
      if (!exl_q) epc_d = pc_q;
    end else begin
      unique case (sel)
        SEL_RST: begin
          pc_d    = RESET_VEC;
          epc_d   = '0;
          exl_d   = 1'b0;
          cause_d = '0;
        end
        SEL_EXC: begin
          pc_d    = EXC_VEC;
          cause_d = exc_code;
          exl_d   = 1'b1;
          flush_d = 1'b1;
          if (!exl_q) epc_d = exc_pc;
        end
        SEL_ERET: begin
          pc_d    = epc_q;
          exl_d   = 1'b0;
          flush_d = 1'b1;
        end
        SEL_HOLD: pc_d = pc_q;
        SEL_JMP:  pc_d = jmp_tgt;
        SEL_BR:   pc_d = br_tgt;
        default:  pc_d = pc_plus;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    epc_q   <= epc_d;
    exl_q   <= exl_d;
    cause_q <= cause_d;
    flush_q <= flush_d;
  end

  assign pc    = pc_q;
  assign epc   = epc_q;
  assign exl   = exl_q;
  assign cause = cause_q;
  assign flush = flush_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a rule-level reference model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, pc_we, br_take, jmp_take, eret, exc_req;
  logic [31:0] br_tgt, jmp_tgt, exc_pc;
  logic [4:0]  exc_code;
  logic [31:0] pc, pc_plus, epc;
  logic        exl, flush;
  logic [4:0]  cause;

  int nvec = 0;
  int nerr = 0;

`ifdef PC_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  pc_ctrl #(.WIDTH(32), .RESET_VEC(32'h0000_3000), .EXC_VEC(32'h0000_3600), .STEP(4)) dut (
    .clk(clk), .rst(rst), .pc_we(pc_we), .br_take(br_take), .br_tgt(br_tgt),
    .jmp_take(jmp_take), .jmp_tgt(jmp_tgt), .eret(eret), .exc_req(exc_req),
    .exc_code(exc_code), .exc_pc(exc_pc), .pc(pc), .pc_plus(pc_plus), .epc(epc),
    .exl(exl), .cause(cause), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state advanced by the next-PC rules.
  logic [31:0] m_pc, m_epc;
  logic        m_exl, m_flush, m_valid = 1'b0;
  logic [4:0]  m_cause;

  task automatic model_trap(input logic [4:0] code, input logic [31:0] ret);
    if (!m_exl) m_epc = ret;
    m_pc = 32'h3600; m_cause = code; m_exl = 1'b1; m_flush = 1'b1;
  endtask

  always @(posedge clk) begin
    m_flush = 1'b0;
    if (rst) begin
      m_pc = 32'h3000; m_epc = 0; m_exl = 0; m_cause = 0; m_valid = 1'b1;
    end else if (exc_req) begin
      model_trap(exc_code, exc_pc);
    end else if (eret && m_exl) begin
      if (CHK && m_epc[1:0] != 0) model_trap(5'd4, m_pc);
      else begin m_pc = m_epc; m_exl = 0; m_flush = 1'b1; end
    end else if (!pc_we) begin
      m_pc = m_pc;
    end else if (jmp_take) begin
      if (CHK && jmp_tgt[1:0] != 0) model_trap(5'd4, m_pc); else m_pc = jmp_tgt;
    end else if (br_take) begin
      if (CHK && br_tgt[1:0] != 0) model_trap(5'd4, m_pc); else m_pc = br_tgt;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model.pc", pc, m_pc);
      chk("model.pc_plus", pc_plus, m_pc + 32'd4);
      chk("model.epc", epc, m_epc);
      chk("model.exl", {31'd0, exl}, {31'd0, m_exl});
      chk("model.cause", {27'd0, cause}, {27'd0, m_cause});
      chk("model.flush", {31'd0, flush}, {31'd0, m_flush});
    end
  end

  task automatic idle();
    rst = 0; pc_we = 1; br_take = 0; jmp_take = 0; eret = 0; exc_req = 0;
    br_tgt = 0; jmp_tgt = 0; exc_pc = 0; exc_code = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst = 1; step(); rst = 0;
    chk("rst.pc", pc, 32'h3000);
    chk("rst.epc", epc, 32'h0);
    chk("rst.exl", {31'd0, exl}, 32'd0);
    chk("rst.flush", {31'd0, flush}, 32'd0);
    chk("rst.pc_plus", pc_plus, 32'h3004);
    step(); chk("seq1", pc, 32'h3004);
    step(); chk("seq2", pc, 32'h3008);
    step(); chk("seq3", pc, 32'h300C);

    pc_we = 0; br_take = 1; br_tgt = 32'h3100;
    step(); chk("stall1", pc, 32'h300C);
    step(); chk("stall2", pc, 32'h300C);
    pc_we = 1; step(); chk("br", pc, 32'h3100);
    jmp_take = 1; jmp_tgt = 32'h3200; step(); chk("jmp_over_br", pc, 32'h3200);
    idle();

    exc_req = 1; exc_code = 5'd12; exc_pc = 32'h3010; pc_we = 0;
    step(); idle();
    chk("exc.pc", pc, 32'h3600);
    chk("exc.epc", epc, 32'h3010);
    chk("exc.cause", {27'd0, cause}, 32'd12);
    chk("exc.exl", {31'd0, exl}, 32'd1);
    chk("exc.flush", {31'd0, flush}, 32'd1);
    step(); chk("exc.flush_off", {31'd0, flush}, 32'd0);
    chk("handler.seq", pc, 32'h3604);

    exc_req = 1; exc_code = 5'd4; exc_pc = 32'h3604;
    step();
    chk("nest.epc", epc, 32'h3010);
    chk("nest.cause", {27'd0, cause}, 32'd4);
    chk("nest.pc", pc, 32'h3600);
    exc_code = 5'd12; exc_pc = 32'h3600;
    step(); idle();
    chk("b2b.flush", {31'd0, flush}, 32'd1);
    chk("b2b.epc", epc, 32'h3010);

    eret = 1; step(); idle();
    chk("eret.pc", pc, 32'h3010);
    chk("eret.exl", {31'd0, exl}, 32'd0);
    chk("eret.flush", {31'd0, flush}, 32'd1);
    step(); chk("eret.flush_off", {31'd0, flush}, 32'd0);

    rst = 1; step(); rst = 0; step(); step();
    chk("pre_eret0", pc, 32'h3008);
    eret = 1; step(); idle();
    chk("eret0.pc", pc, 32'h300C);
    chk("eret0.flush", {31'd0, flush}, 32'd0);

    exc_req = 1; exc_code = 5'd12; exc_pc = 32'h300C; step();
    rst = 1; step(); idle();
    chk("rst_mid.pc", pc, 32'h3000);
    chk("rst_mid.exl", {31'd0, exl}, 32'd0);
    chk("rst_mid.epc", epc, 32'h0);
    chk("rst_mid.flush", {31'd0, flush}, 32'd0);

    jmp_take = 1; jmp_tgt = 32'hFFFF_FFFC; step(); idle();
    chk("wrap.pc_plus", pc_plus, 32'h0);
    step(); chk("wrap.pc", pc, 32'h0);

    rst = 1; step(); rst = 0; step();
    pc_we = 0; jmp_take = 1; jmp_tgt = 32'h3102; step();
    chk("mis_stall", pc, 32'h3004);
    pc_we = 1; step(); idle();
    if (CHK) begin
      chk("align.pc", pc, 32'h3600);
      chk("align.cause", {27'd0, cause}, 32'd4);
      chk("align.epc", epc, 32'h3004);
    end else begin
      chk("noalign.pc", pc, 32'h3102);
    end

    rst = 1; step(); rst = 0;
    exc_req = 1; exc_code = 5'd12; exc_pc = 32'h3000; br_take = 1; br_tgt = 32'h3001;
    step(); idle();
    chk("exc_over_align.cause", {27'd0, cause}, 32'd12);
    chk("exc_over_align.epc", epc, 32'h3000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
